pmem_arbiter: RTL

Sits between the mp4 core's icache and dcache and the single burst memory port (`pmem_*`, `mem_resp`) driven out of the `mp4` top. Grants one 256-bit cacheline transaction at a time and serialises/deserialises it into four 64-bit beats. Fair arbitration under contention keeps instruction fetch from being starved by the memory stage.

---
 rtl/pmem_arbiter_pkg.sv | 30 +++
 rtl/pmem_arbiter_if.sv | 36 +++
 rtl/pmem_arbiter_cacheline_adaptor.sv | 54 +++++
 rtl/pmem_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared constants and types for the burst memory arbiter.
package pmem_pkg;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BEAT_WIDTH  = 64;
  localparam int unsigned BURST_LEN   = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned CNT_WIDTH   = $clog2(BURST_LEN);
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  // Arbiter FSM encoding.
  typedef logic [1:0] pmem_state_t;
  localparam pmem_state_t StIdle  = 2'd0;
  localparam pmem_state_t StBurst = 2'd1;
  localparam pmem_state_t StDone  = 2'd2;

  typedef enum logic {
    I = 1'b0,
    D = 1'b1
  } client_t;

  // Clear the byte-within-line offset bits.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] a;
    a = addr;
    a[OFFSET_BITS-1:0] = '0;
    return a;
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Cache-side and memory-side bus of the arbiter, grouped into one bundle.
interface pmem_arbiter_if;
  import pmem_pkg::*;

  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [BEAT_WIDTH-1:0] pmem_wdata;
  logic [BEAT_WIDTH-1:0] pmem_rdata;
  logic                  mem_resp;

  // Arbiter view.
  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Caches plus memory view.
  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/pmem_arbiter_cacheline_adaptor.sv
// Line buffer and beat counter: assembles read beats, serialises write beats.
module cacheline_adaptor
  import pmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  load_write_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  input  logic                  beat_ack_i,
  input  logic                  write_i,
  input  logic [BEAT_WIDTH-1:0] rdata_i,
  output logic [LINE_WIDTH-1:0] line_next_o,
  output logic [BEAT_WIDTH-1:0] wbeat_o,
  output logic                  last_o
);

  logic [LINE_WIDTH-1:0] line_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [BEAT_WIDTH-1:0] wbeat_q;

  // Buffer contents including the read beat accepted this cycle.
  always_comb begin
    cnt_nxt     = cnt_q + CNT_WIDTH'(1);
    line_next_o = line_q;
    if (beat_ack_i && !write_i) begin
      line_next_o[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = rdata_i;
    end
    last_o  = (cnt_q == CNT_WIDTH'(BURST_LEN - 1));
    wbeat_o = wbeat_q;
  end

  // Load on grant, then step one beat per accepted memory response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q  <= '0;
      cnt_q   <= '0;
      wbeat_q <= '0;
    end else if (load_i) begin
      line_q  <= wdata_i;
      cnt_q   <= '0;
      // Beat 0 is ready before the write request rises.
      wbeat_q <= load_write_i ? wdata_i[BEAT_WIDTH-1:0] : '0;
    end else if (beat_ack_i) begin
      line_q <= line_next_o;
      cnt_q  <= cnt_nxt;
      if (write_i) begin
        wbeat_q <= line_q[cnt_nxt*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Fair icache/dcache arbiter onto a single 4-beat burst memory port.
module pmem_arbiter
  import pmem_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  pmem_arbiter_if.master bus_io
);

  pmem_state_t           state_q, state_d;
  client_t               client_q, last_grant_q, grant_client;
  logic                  write_q, req_rd_q, req_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q, grant_addr;
  logic                  i_resp_q, d_resp_q;
  logic [LINE_WIDTH-1:0] i_rdata_q, d_rdata_q, line_next;
  logic [BEAT_WIDTH-1:0] wbeat;
  logic                  i_pend, d_pend, grant, grant_write;
  logic                  burst_active, beat_ack, cnt_last, last_beat;

  // Arbitration and next-state decode.
  always_comb begin
    i_pend       = bus_io.i_read;
    d_pend       = bus_io.d_read | bus_io.d_write;
    // Under contention the source not granted last wins.
    grant_client = (i_pend && (!d_pend || last_grant_q == D)) ? I : D;
    grant        = (state_q == StIdle) && (i_pend || d_pend);
    // Write wins if the dcache raises both read and write.
    grant_write  = (grant_client == D) && bus_io.d_write;
    grant_addr   = line_align((grant_client == I) ? bus_io.i_address : bus_io.d_address);
    burst_active = req_rd_q | req_wr_q;
    beat_ack     = (state_q == StBurst) && burst_active && bus_io.mem_resp;
    last_beat    = beat_ack && cnt_last;
    state_d      = state_q;
    case (state_q)
      StIdle:  if (grant) state_d = StBurst;
      StBurst: if (last_beat) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM, transaction latches and registered client outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      client_q     <= D;
      last_grant_q <= D;
      write_q      <= 1'b0;
      addr_q       <= '0;
      req_rd_q     <= 1'b0;
      req_wr_q     <= 1'b0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_resp_q <= last_beat && (client_q == I);
      d_resp_q <= last_beat && (client_q == D);
      if (grant) begin
        client_q     <= grant_client;
        last_grant_q <= grant_client;
        write_q      <= grant_write;
        addr_q       <= grant_addr;
      end
      // First BURST cycle raises the request; the last beat drops it.
      if (state_q == StBurst && !burst_active) begin
        req_rd_q <= !write_q;
        req_wr_q <= write_q;
      end else if (last_beat) begin
        req_rd_q <= 1'b0;
        req_wr_q <= 1'b0;
      end
      if (last_beat && !write_q) begin
        if (client_q == I) i_rdata_q <= line_next;
        else               d_rdata_q <= line_next;
      end
    end
  end

  cacheline_adaptor u_adaptor (
    .clk          (clk),
    .rst          (rst),
    .load_i       (grant),
    .load_write_i (grant_write),
    .wdata_i      (bus_io.d_wdata),
    .beat_ack_i   (beat_ack),
    .write_i      (write_q),
    .rdata_i      (bus_io.pmem_rdata),
    .line_next_o  (line_next),
    .wbeat_o      (wbeat),
    .last_o       (cnt_last)
  );

  assign bus_io.i_rdata      = i_rdata_q;
  assign bus_io.i_resp       = i_resp_q;
  assign bus_io.d_rdata      = d_rdata_q;
  assign bus_io.d_resp       = d_resp_q;
  assign bus_io.pmem_read    = req_rd_q;
  assign bus_io.pmem_write   = req_wr_q;
  assign bus_io.pmem_address = addr_q;
  assign bus_io.pmem_wdata   = wbeat;

endmodule
